ntt_poly_drain: RTL and testbench

Output-side collector for the streaming NTT/INTT pipeline. It accepts the coefficient pairs that leave the last butterfly stage in bit-reversed order, two per cycle with no back-pressure, and stores them in a ping-pong pair of polynomial buffers. It then replays each polynomial in natural order, one coefficient per beat, over a valid/ready interface. This lets the next polynomial stream in while the previous one drains.

---
 rtl/ntt_poly_drain.sv | 154 +++++++++++++++
 tb/tb_ntt_poly_drain.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_poly_drain.sv
// Ping-pong collector for bit-reversed NTT output pairs; replays each polynomial
// in natural order over a valid/ready stream through a 2-entry prefetch buffer.
//
// state | meaning
// EMPTY | bank free, no beats written
// FILL  | bank partially written by the input side
// FULL  | all N/2 pair beats written, waiting for the read side
// DRAIN | read side owns the bank until coefficient N-1 leaves the output
module ntt_poly_drain #(
    parameter int WIDTH = 12,
    parameter int N     = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             overflow
);
    localparam int L = $clog2(N);
    localparam int H = N / 2;

    typedef enum logic [1:0] {EMPTY, FILL, FULL, DRAIN} bank_t;

    bank_t            state [2];
    logic             wr_sel;
    logic             iss_sel;
    logic             rd_sel;
    logic [L-2:0]     wr_cnt;
    logic [L-1:0]     rd_cnt;

    logic [WIDTH-1:0] mem_lo [2][H];
    logic [WIDTH-1:0] mem_hi [2][H];

    logic             rd_vld_q;
    logic             rd_last_q;
    logic [WIDTH-1:0] rd_data_q;

    logic [1:0]       buf_cnt;
    logic [WIDTH-1:0] buf_d0;
    logic [WIDTH-1:0] buf_d1;
    logic             buf_l0;
    logic             buf_l1;
    logic             ovf_q;

    logic             wr_en;
    logic             pop;
    logic             issue;
    logic             iss_end;
    logic             pre_sel;

    function automatic logic [L-2:0] bitrev(input logic [L-2:0] v);
        logic [L-2:0] r;
        for (int i = 0; i < L - 1; i++) r[i] = v[L-2-i];
        return r;
    endfunction

    always_comb begin
        in_ready  = (state[wr_sel] == EMPTY) || (state[wr_sel] == FILL);
        wr_en     = in_valid && in_ready;
        out_valid = (buf_cnt != 2'd0);
        pop       = out_valid && out_ready;
        // Credit check: buffered + in-flight entries must stay within two after this cycle.
        issue     = (state[iss_sel] == DRAIN) &&
                    (({1'b0, buf_cnt} + {2'b00, rd_vld_q}) < (3'd2 + {2'b00, pop}));
        iss_end   = issue && (rd_cnt == {L{1'b1}});
        // Claim the next FULL bank in the same cycle the current one issues its last read.
        pre_sel   = iss_end ? ~iss_sel : iss_sel;
        out_data  = buf_d0;
        out_last  = out_valid && buf_l0;
        overflow  = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_lo[wr_sel][bitrev(wr_cnt)] <= in_data0;
            mem_hi[wr_sel][bitrev(wr_cnt)] <= in_data1;
        end
        if (issue) begin
            rd_data_q <= rd_cnt[L-1] ? mem_hi[iss_sel][rd_cnt[L-2:0]]
                                     : mem_lo[iss_sel][rd_cnt[L-2:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state[0]  <= EMPTY;
            state[1]  <= EMPTY;
            wr_sel    <= 1'b0;
            iss_sel   <= 1'b0;
            rd_sel    <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            buf_cnt   <= 2'd0;
            buf_d0    <= '0;
            buf_d1    <= '0;
            buf_l0    <= 1'b0;
            buf_l1    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (in_valid && !in_ready) ovf_q <= 1'b1;

            if (wr_en) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == {(L-1){1'b1}}) begin
                    state[wr_sel] <= FULL;
                    wr_sel        <= ~wr_sel;
                end else begin
                    state[wr_sel] <= FILL;
                end
            end

            if (state[pre_sel] == FULL) state[pre_sel] <= DRAIN;

            if (issue) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (iss_end) iss_sel <= ~iss_sel;
            end
            rd_vld_q  <= issue;
            rd_last_q <= iss_end;

            buf_cnt <= buf_cnt + {1'b0, rd_vld_q} - {1'b0, pop};
            if (pop) begin
                if (buf_cnt == 2'd2) begin
                    buf_d0 <= buf_d1;
                    buf_l0 <= buf_l1;
                end else if (rd_vld_q) begin
                    buf_d0 <= rd_data_q;
                    buf_l0 <= rd_last_q;
                end
            end else if (buf_cnt == 2'd0 && rd_vld_q) begin
                buf_d0 <= rd_data_q;
                buf_l0 <= rd_last_q;
            end
            if (rd_vld_q && ((buf_cnt == 2'd1 && !pop) || (buf_cnt == 2'd2 && pop))) begin
                buf_d1 <= rd_data_q;
                buf_l1 <= rd_last_q;
            end

            if (pop && buf_l0) begin
                state[rd_sel] <= EMPTY;
                rd_sel        <= ~rd_sel;
            end
        end
    end
endmodule

// File: tb/tb_ntt_poly_drain.sv
// Directed bench for ntt_poly_drain: scoreboard of expected natural-order
// coefficients, checked on every presented beat at the falling edge.
module tb_ntt_poly_drain;
    localparam int WIDTH = 12;
    localparam int N     = 256;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data0 = '0;
    logic [WIDTH-1:0] in_data1 = '0;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             overflow;

    ntt_poly_drain #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_data0(in_data0), .in_data1(in_data1), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int hs_cnt = 0;
    int cyc = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int tmp;
    bit mon_en = 1'b0;
    int rdy_mode = 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int bitrev8(input int v);
        int r = 0;
        for (int i = 0; i < 8; i++) if (v[i]) r |= (1 << (7 - i));
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready: 0 = held low, 1 = held high, 2 = random 30% duty
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 99) < 30);
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en && rst_n && !clear && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious out_valid", 1, 0);
            end else begin
                chk("out_data", int'(out_data), exp_q[0] & 4095);
                chk("out_last", int'(out_last), exp_q[0] >> 12);
                if (out_ready) begin
                    tmp = exp_q.pop_front();
                    if (hs_cnt == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    hs_cnt++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int base, input int nbeats, input bit gaps, input bit push_exp);
        for (int k = 0; k < nbeats; k++) begin
            if (gaps && (k % 5 == 2)) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_data0 = 12'((base + bitrev8(2 * k)) & 4095);
            in_data1 = 12'((base + bitrev8(2 * k + 1)) & 4095);
            chk("in_ready during fill", int'(in_ready), 1);
            step();
        end
        in_valid = 1'b0;
        if (push_exp)
            for (int i = 0; i < N; i++)
                exp_q.push_back(((base + i) & 4095) | ((i == N - 1) ? 4096 : 0));
    endtask

    task automatic wait_drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            step();
            t++;
        end
        chk({tag, " beats left after drain"}, exp_q.size(), 0);
        repeat (3) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " in_ready"}, int'(in_ready), 1);
        chk({tag, " out_valid"}, int'(out_valid), 0);
        chk({tag, " out_data"}, int'(out_data), 0);
        chk({tag, " out_last"}, int'(out_last), 0);
        chk({tag, " overflow"}, int'(overflow), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int t;
        repeat (2) step();
        check_reset_outputs("reset");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // single polynomial with latency check
        hs_cnt = 0;
        fill(0, 128, 1'b0, 1'b1);
        chk("lat edge0 out_valid", int'(out_valid), 0);
        step();
        chk("lat edge1 out_valid", int'(out_valid), 0);
        step();
        chk("lat edge2 out_valid", int'(out_valid), 0);
        step();
        chk("lat edge3 out_valid", int'(out_valid), 1);
        chk("lat edge3 out_data", int'(out_data), 0);
        wait_drain("single");
        chk("single beats", hs_cnt, 256);
        chk("single contiguous span", last_cyc - first_cyc + 1, 256);

        // back-to-back, three polynomials
        hs_cnt = 0;
        fill(0, 128, 1'b0, 1'b1);
        fill(256, 128, 1'b0, 1'b1);
        t = 0;
        while (!in_ready && t < 2000) begin step(); t++; end
        chk("b2b in_ready wait", int'(in_ready), 1);
        fill(512, 128, 1'b0, 1'b1);
        wait_drain("b2b");
        chk("b2b beats", hs_cnt, 768);
        chk("b2b contiguous span", last_cyc - first_cyc + 1, 768);
        chk("b2b overflow", int'(overflow), 0);

        // back-pressure at 30% duty, with input gaps
        hs_cnt   = 0;
        rdy_mode = 2;
        fill(0, 128, 1'b1, 1'b1);
        wait_drain("backpressure");
        chk("backpressure beats", hs_cnt, 256);
        rdy_mode = 1;
        step();

        // overflow: two buffered polynomials, then a dropped beat
        hs_cnt   = 0;
        rdy_mode = 0;
        step();
        fill(100, 128, 1'b0, 1'b1);
        fill(300, 128, 1'b0, 1'b1);
        repeat (2) step();
        chk("ovf in_ready low", int'(in_ready), 0);
        chk("ovf before drop", int'(overflow), 0);
        in_valid = 1'b1;
        in_data0 = 12'hABC;
        in_data1 = 12'h123;
        step();
        in_valid = 1'b0;
        chk("ovf after drop", int'(overflow), 1);
        repeat (5) step();
        rdy_mode = 1;
        wait_drain("ovf");
        chk("ovf beats", hs_cnt, 512);
        chk("ovf sticky", int'(overflow), 1);
        chk("ovf in_ready after drain", int'(in_ready), 1);

        // clear mid-fill at k=60, then a full fill
        fill(2000, 60, 1'b0, 1'b0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check_reset_outputs("clear");
        hs_cnt = 0;
        fill(3000, 128, 1'b0, 1'b1);
        wait_drain("clear");
        chk("clear beats", hs_cnt, 256);
        chk("clear overflow", int'(overflow), 0);

        // reset at output beat 100, then a fresh polynomial
        hs_cnt = 0;
        fill(700, 128, 1'b0, 1'b1);
        t = 0;
        while (hs_cnt < 100 && t < 2000) begin @(posedge clk); t++; end
        chk("rst reached beat 100", int'(hs_cnt >= 100), 1);
        #1;
        rst_n  = 1'b0;
        mon_en = 1'b0;
        exp_q.delete();
        step();
        check_reset_outputs("midreset");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        hs_cnt = 0;
        fill(1234, 128, 1'b0, 1'b1);
        wait_drain("midreset");
        chk("midreset beats", hs_cnt, 256);
        chk("midreset contiguous span", last_cyc - first_cyc + 1, 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
